// File: rtl/psum_arb_pkg.sv
// psum_arb_pkg: shared defaults and requester indices for the PSUM SRAM arbiter
package psum_arb_pkg;
    localparam int NUM_REQ    = 3;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 128;
    localparam int STARVE_LIM = 8;
    localparam int REQ_OFIFO  = 0;
    localparam int REQ_NORM   = 1;
    localparam int REQ_HOST   = 2;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick, first masked request at or after ptr, wrapping
// Ports: req/mask (N) candidate set, ptr (PW) start index, gnt (N) one-hot-or-zero pick
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    logic [N-1:0] cand;
    logic         hit;
    always_comb begin
        cand = req & mask;
        gnt  = '0;
        hit  = 1'b0;
        for (int i = 0; i < N; i++)
            if (!hit && cand[i] && PW'(i) >= ptr) begin
                gnt[i] = 1'b1;
                hit    = 1'b1;
            end
        for (int i = 0; i < N; i++)
            if (!hit && cand[i]) begin
                gnt[i] = 1'b1;
                hit    = 1'b1;
            end
    end
endmodule

// File: rtl/psum_mem_arbiter.sv
// psum_mem_arbiter: shares the single-port PSUM SRAM between NUM_REQ requesters
// Ports: req/wen/addr/wdata per requester in, gnt (comb) and rvalid per requester out,
// rdata shared read data, mem_* registered active-low SRAM command, mem_dout SRAM data,
// busy = request pending or read in flight. Port 0 has priority unless another port starves.
module psum_mem_arbiter #(
    parameter int NUM_REQ    = psum_arb_pkg::NUM_REQ,
    parameter int ADDR_W     = psum_arb_pkg::ADDR_W,
    parameter int DATA_W     = psum_arb_pkg::DATA_W,
    parameter int STARVE_LIM = psum_arb_pkg::STARVE_LIM
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        wen,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_cen,
    output logic                      mem_wen,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_din,
    input  logic [DATA_W-1:0]         mem_dout,
    output logic                      busy
);
    import psum_arb_pkg::*;
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [NUM_REQ-1:0] LOW_MASK = ~(NUM_REQ'(1) << REQ_OFIFO);
    logic [PW-1:0]      rr_ptr, gidx, rd_idx1, rd_idx2;
    logic [CW-1:0]      starve_cnt [1:NUM_REQ-1];
    logic [NUM_REQ-1:0] starved, pick_s, pick_n;
    logic               rd_v1, rd_v2;
    always_comb begin
        starved = '0;
        for (int k = 1; k < NUM_REQ; k++)
            starved[k] = req[k] && starve_cnt[k] == CW'(STARVE_LIM);
    end
    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick_starved (
        .req(starved), .mask(LOW_MASK), .ptr(rr_ptr), .gnt(pick_s)
    );
    rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick_normal (
        .req(req), .mask(LOW_MASK), .ptr(rr_ptr), .gnt(pick_n)
    );
    assign gnt = |starved ? pick_s : req[REQ_OFIFO] ? ~LOW_MASK : pick_n;
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (gnt[i]) gidx = PW'(i);
    end
    always_comb begin
        rvalid = '0;
        if (rd_v2) rvalid[rd_idx2] = 1'b1;
    end
    assign rdata = mem_dout;
    assign busy  = |req | rd_v1 | rd_v2;
    // Read tag pipe: stage 1 tracks the issued SRAM command, stage 2 the cycle its data appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_cen  <= 1'b1;
            mem_wen  <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
            rr_ptr   <= PW'(1);
            rd_v1    <= 1'b0;
            rd_v2    <= 1'b0;
            rd_idx1  <= '0;
            rd_idx2  <= '0;
            for (int k = 1; k < NUM_REQ; k++) starve_cnt[k] <= '0;
        end else begin
            mem_cen <= ~|gnt;
            mem_wen <= ~(|gnt & wen[gidx]);
            if (|gnt) begin
                mem_addr <= addr[int'(gidx)*ADDR_W +: ADDR_W];
                mem_din  <= wdata[int'(gidx)*DATA_W +: DATA_W];
            end
            if (|gnt && gidx != PW'(REQ_OFIFO))
                rr_ptr <= gidx == PW'(NUM_REQ - 1) ? PW'(1) : gidx + PW'(1);
            rd_v1   <= |gnt & ~wen[gidx];
            rd_idx1 <= gidx;
            rd_v2   <= rd_v1;
            rd_idx2 <= rd_idx1;
            for (int k = 1; k < NUM_REQ; k++)
                starve_cnt[k] <= !(req[k] && !gnt[k]) ? '0 :
                                 starve_cnt[k] == CW'(STARVE_LIM) ? starve_cnt[k] : starve_cnt[k] + CW'(1);
        end
    end
endmodule
